rsa_operand_loader: RTL
=======================

# rsa_operand_loader

- Sits directly upstream of `rsa_hw`, between the DMA receive path and the exponentiation core.
- Captures 1024-bit DMA words into the operand registers `N_Q`, `R_N_Q`, `R2_N_Q`, `M`, `t` and `t_len` according to a slot selector.
- Tracks which operands are valid and checks them before starting the core.
- Freezes all operands and emits a single-cycle start pulse while the core runs.

## Interface
Parameters:
- `DATA_W`, 1024, operand width.
- `LEN_W`, 32, exponent-length width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous active-low.
- `load_sel` in 4: slot select. 1=N, 2=R_N, 3=R2_N, 4=M, 5=t, 6=t_len (low `LEN_W` bits of `load_data`). 0 and 7..15 are invalid.
- `load_valid` in 1: `load_data`/`load_sel` valid.
- `load_data` in DATA_W: DMA word.
- `load_ready` out 1: loader accepts a word this cycle.
- `start_req` in 1: compute request; its rising edge is the start event.
- `clear_req` in 1: clears the valid mask and error flags.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_start` out 1: one-cycle start pulse to the core.
- `N_Q`, `R_N_Q`, `R2_N_Q`, `M_Q`, `t_Q` out DATA_W each: operand registers.
- `t_len_Q` out LEN_W: exponent length.
- `loaded_mask` out 6: bit k-1 set once slot k has been written.
- `busy` out 1: high while in RUN.
- `err_sel` out 1: sticky; an invalid slot was written.
- `err_start` out 1: sticky; a start was rejected.

## Operation
States: IDLE, RUN.

IDLE:
- `load_ready` = 1 unless a deferred start is pending.
- Handshake: `load_valid & load_ready`.
  - Valid slot: write `load_data` to that slot and set its mask bit. Rewriting an already loaded slot overwrites it; its mask bit stays 1.
  - Invalid slot: no register write; set `err_sel`.
- Start event: `start_req & ~start_q`, where `start_q` is `start_req` registered.
  - If it coincides with a handshake, the load completes and the start is held pending. The pending start is evaluated the next cycle, with `load_ready` = 0 in that cycle.
- Start evaluation accepts when all of these hold:
  - `loaded_mask == 6'h3F`
  - `1 <= t_len_Q <= DATA_W`
  - `N_Q[0] == 1` (odd modulus)
- Accept: `core_start` = 1 for one cycle; go to RUN.
- Reject: set `err_start`; stay in IDLE; no pulse.
- `clear_req` (IDLE only): mask and errors go to 0. Operand values are kept.
  - If `clear_req` coincides with a handshake, the clear wins for the mask, and the written slot's bit ends at 0. The data is still written.

RUN:
- `busy` = 1, `load_ready` = 0; all operand registers frozen.
- `start_req`, `clear_req` and `load_valid` are ignored; no error is flagged.
- `core_done` returns the block to IDLE. The M mask bit is cleared there, so each new message must be reloaded; N, R_N, R2_N, t and t_len stay valid.
- `start_q` keeps tracking in all states. A `start_req` held high across `core_done` therefore does not re-trigger.

Reset, asynchronous at any time, including mid-RUN:
- State goes to IDLE.
- All operand registers, `loaded_mask`, errors, `start_q` and pending go to 0.
- `core_start`, `busy` and `load_ready` are 0 while `resetn` = 0.
- `load_ready` rises in the first clock after release.
- The core shares `resetn`, so no `core_done` is expected after a mid-RUN reset.

## Timing
- Load: write visible on outputs the cycle after the handshake edge; throughput is one word per cycle.
- Start:
  - `start_req` rises at edge n and `start_q` is low.
  - `core_start` is high in cycle n+1 on accept, registered.
  - `busy` goes high from cycle n+1.
  - With a coinciding load, everything shifts by one cycle.
- `err_sel` and `err_start` are set the cycle after the offending event.
- `core_done` at edge m: `busy` low and `load_ready` high from cycle m+1.
- All outputs are registered; no combinational path from inputs to `core_start`.

## Test plan
- Load slots 1..6 with N=0xC5 (odd), R_N, R2_N, M=0x42, t=0x11, t_len=5, then pulse `start_req` → `loaded_mask`=0x3F, then exactly one `core_start` cycle, `busy`=1, operands unchanged during RUN.
- Load 5 slots (omit t_len) then start → no `core_start`, `err_start`=1; `clear_req` → `err_start`=0, mask=0.
- `load_sel`=0 and 9 with valid → `err_sel`=1, mask unchanged, no register modified; t_len=0 or 1025 and N even each cause start rejection.
- Handshake on slot 4 in the same cycle as `start_req` rising with the other 5 slots loaded → M written; `core_start` one cycle later than usual, `load_ready` low for that cycle.
- RUN: drive `load_valid` slot 1 with 0xFFFF, then `core_done` while `start_req` stays high → N unchanged, return to IDLE, mask=0x37, no second `core_start`.
- Assert `resetn`=0 mid-RUN asynchronously → `busy`, `core_start`, mask and all operands 0 immediately; `load_ready`=1 one cycle after release.

Source files
------------

// File: rtl/rsa_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : rsa_operand_loader
// Purpose  : Captures DMA operand words (N, R_N, R2_N, M, t, t_len) for the
//            RSA exponentiation core, tracks which slots are loaded, validates
//            the operand set on a start request and issues a single-cycle
//            start pulse. Operands are frozen while the core is running.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_operand_loader #(
  parameter int DATA_W = 1024,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        load_sel,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start_req,
  input  logic              clear_req,
  input  logic              core_done,
  output logic              core_start,
  output logic [DATA_W-1:0] N_Q,
  output logic [DATA_W-1:0] R_N_Q,
  output logic [DATA_W-1:0] R2_N_Q,
  output logic [DATA_W-1:0] M_Q,
  output logic [DATA_W-1:0] t_Q,
  output logic [LEN_W-1:0]  t_len_Q,
  output logic [5:0]        loaded_mask,
  output logic              busy,
  output logic              err_sel,
  output logic              err_start
);

  // Controller states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Slot selector encodings
  localparam logic [3:0] SLOT_N     = 4'd1;
  localparam logic [3:0] SLOT_R_N   = 4'd2;
  localparam logic [3:0] SLOT_R2_N  = 4'd3;
  localparam logic [3:0] SLOT_M     = 4'd4;
  localparam logic [3:0] SLOT_T     = 4'd5;
  localparam logic [3:0] SLOT_T_LEN = 4'd6;

  // Mask bit positions (slot k lives in bit k-1)
  localparam int MASK_N     = 0;
  localparam int MASK_R_N   = 1;
  localparam int MASK_R2_N  = 2;
  localparam int MASK_M     = 3;
  localparam int MASK_T     = 4;
  localparam int MASK_T_LEN = 5;

  localparam logic [5:0]       MASK_ALL = 6'h3F;
  // Largest legal exponent length is the operand width itself
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);

  // State / control flops
  logic [0:0]        state_q,       state_d;
  logic              start_q,       start_d;
  logic              pending_q,     pending_d;
  logic              load_ready_q,  load_ready_d;
  logic              core_start_q,  core_start_d;
  logic              busy_q,        busy_d;
  logic [5:0]        mask_q,        mask_d;
  logic              err_sel_q,     err_sel_d;
  logic              err_start_q,   err_start_d;

  // Operand flops
  logic [DATA_W-1:0] n_q,           n_d;
  logic [DATA_W-1:0] r_n_q,         r_n_d;
  logic [DATA_W-1:0] r2_n_q,        r2_n_d;
  logic [DATA_W-1:0] m_q,           m_d;
  logic [DATA_W-1:0] t_q,           t_d;
  logic [LEN_W-1:0]  t_len_q,       t_len_d;

  // Decoded events
  logic              handshake;
  logic              start_evt;
  logic              operands_ok;
  logic              evaluate;

  // Input-side events; handshake only possible in IDLE with ready asserted
  always_comb begin
    handshake   = (state_q == ST_IDLE) && load_valid && load_ready_q;
    start_evt   = start_req && !start_q;
    operands_ok = (mask_q == MASK_ALL) &&
                  (t_len_q != '0) &&
                  (t_len_q <= MAX_LEN) &&
                  n_q[0];
    // A start coinciding with a load is deferred one cycle so the check
    // sees the freshly written operand.
    evaluate    = pending_q || (start_evt && !handshake);
  end

  // Next-state logic for the controller, operand registers and flags
  always_comb begin
    state_d      = state_q;
    start_d      = start_req;
    pending_d    = 1'b0;
    core_start_d = 1'b0;
    mask_d       = mask_q;
    err_sel_d    = err_sel_q;
    err_start_d  = err_start_q;
    n_d          = n_q;
    r_n_d        = r_n_q;
    r2_n_d       = r2_n_q;
    m_d          = m_q;
    t_d          = t_q;
    t_len_d      = t_len_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          case (load_sel)
            SLOT_N: begin
              n_d            = load_data;
              mask_d[MASK_N] = 1'b1;
            end
            SLOT_R_N: begin
              r_n_d            = load_data;
              mask_d[MASK_R_N] = 1'b1;
            end
            SLOT_R2_N: begin
              r2_n_d            = load_data;
              mask_d[MASK_R2_N] = 1'b1;
            end
            SLOT_M: begin
              m_d            = load_data;
              mask_d[MASK_M] = 1'b1;
            end
            SLOT_T: begin
              t_d            = load_data;
              mask_d[MASK_T] = 1'b1;
            end
            SLOT_T_LEN: begin
              t_len_d            = load_data[LEN_W-1:0];
              mask_d[MASK_T_LEN] = 1'b1;
            end
            default: begin
              err_sel_d = 1'b1;
            end
          endcase
        end

        pending_d = start_evt && handshake;

        if (evaluate) begin
          if (operands_ok) begin
            core_start_d = 1'b1;
            state_d      = ST_RUN;
          end else begin
            err_start_d  = 1'b1;
          end
        end

        // Clear overrides any bit set in the same cycle; operand data stays
        if (clear_req) begin
          mask_d      = '0;
          err_sel_d   = 1'b0;
          err_start_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (core_done) begin
          state_d        = ST_IDLE;
          // Every run consumes its message; the key material stays valid
          mask_d[MASK_M] = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    load_ready_d = (state_d == ST_IDLE) && !pending_d;
    busy_d       = (state_d == ST_RUN);
  end

  // Controller and flag registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      pending_q    <= 1'b0;
      load_ready_q <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      mask_q       <= '0;
      err_sel_q    <= 1'b0;
      err_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      mask_q       <= mask_d;
      err_sel_q    <= err_sel_d;
      err_start_q  <= err_start_d;
    end
  end

  // Operand registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_q     <= '0;
      r_n_q   <= '0;
      r2_n_q  <= '0;
      m_q     <= '0;
      t_q     <= '0;
      t_len_q <= '0;
    end else begin
      n_q     <= n_d;
      r_n_q   <= r_n_d;
      r2_n_q  <= r2_n_d;
      m_q     <= m_d;
      t_q     <= t_d;
      t_len_q <= t_len_d;
    end
  end

  // All outputs come straight from flops
  always_comb begin
    load_ready  = load_ready_q;
    core_start  = core_start_q;
    busy        = busy_q;
    loaded_mask = mask_q;
    err_sel     = err_sel_q;
    err_start   = err_start_q;
    N_Q         = n_q;
    R_N_Q       = r_n_q;
    R2_N_Q      = r2_n_q;
    M_Q         = m_q;
    t_Q         = t_q;
    t_len_Q     = t_len_q;
  end

endmodule
`default_nettype wire
